// File: rtl/cyborg65r2_coarse_pkg.sv
// Shared constants, FSM state type and Gray-to-binary helper for the
// coarse counter decoder.
//   CNT_W    : width of the coarse Gray counter (6)
//   SUM_W    : width of the decimated sum (12, covers 63*64 = 4032)
//   state_t  : decoder FSM states (IDLE, PRIME, RUN)
//   gray2bin : binary-reflected Gray to binary conversion
package cyborg65r2_coarse_pkg;

    localparam int CNT_W = 6;
    localparam int SUM_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Each binary bit is the XOR of all Gray bits at or above it,
    // computed as a running prefix from the MSB down.
    function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
        logic [CNT_W-1:0] b;
        b[CNT_W-1] = g[CNT_W-1];
        for (int i = CNT_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/cyborg65r2_coarse_decode_gray2bin.sv
// Combinational 6-bit Gray-to-binary converter (prefix XOR).
//   grey : Gray-coded count
//   bin  : binary count
module cyborg65r2_gray2bin
    import cyborg65r2_coarse_pkg::*;
(
    input  logic [CNT_W-1:0] grey,
    output logic [CNT_W-1:0] bin
);

    assign bin = gray2bin(grey);

endmodule

// File: rtl/cyborg65r2_coarse_decode.sv
// Coarse counter decoder: converts the main and delayed-phase Gray counts
// to binary, produces the modulo-64 increment between successive valid
// samples, sums DECIM increments into a decimated output, and flags
// over-large steps (sticky) and main/delayed phase disagreement (pulse).
//
// Ports
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   in_valid     : sample pair on grey_in / grey_del_in is valid
//   grey_in      : Gray count, main phase
//   grey_del_in  : Gray count, delayed-clock phase
//   clr_ovr      : clears ovr_flag (a simultaneous set wins)
//   diff_out     : increment between successive valid samples, mod 64
//   diff_valid   : one-cycle qualifier for diff_out
//   sum_out      : sum of the last DECIM increments (held between pulses)
//   sum_valid    : one-cycle qualifier for sum_out, coincident with the
//                  DECIM-th diff_valid
//   ovr_flag     : sticky, set when a qualified increment exceeds MAX_STEP
//   mis_flag     : one-cycle pulse in a valid sample's diff slot when
//                  (bin - bin_del) mod 64 is neither 0 nor 1
//   fsm_state    : current FSM state, for observation
//
// Valid/ready: there is no back-pressure. A sample is accepted on every
// rising edge where in_valid is high; each *_valid output is a single-cycle
// strobe that the consumer must take in the cycle it is high.
//
// Timing: a sample taken at edge n is registered in stage 1 at edge n and
// its diff/mis results are registered at edge n+1.
module cyborg65r2_coarse_decode
    import cyborg65r2_coarse_pkg::*;
#(
    parameter int DECIM    = 8,
    parameter int MAX_STEP = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] grey_in,
    input  logic [CNT_W-1:0] grey_del_in,
    input  logic             clr_ovr,
    output logic [CNT_W-1:0] diff_out,
    output logic             diff_valid,
    output logic [SUM_W-1:0] sum_out,
    output logic             sum_valid,
    output logic             ovr_flag,
    output logic             mis_flag,
    output logic [1:0]       fsm_state
);

    localparam int         CNT_BITS = 7;
    localparam logic [6:0] LAST_CNT = CNT_BITS'(DECIM - 1);

    // Stage 1: binary conversions of both phases plus qualifier
    logic [CNT_W-1:0] bin_c;
    logic [CNT_W-1:0] bin_del_c;
    logic [CNT_W-1:0] s1_bin;
    logic [CNT_W-1:0] s1_bin_del;
    logic             s1_valid;

    cyborg65r2_gray2bin u_g2b_main (
        .grey (grey_in),
        .bin  (bin_c)
    );

    cyborg65r2_gray2bin u_g2b_del (
        .grey (grey_del_in),
        .bin  (bin_del_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_bin     <= '0;
            s1_bin_del <= '0;
            s1_valid   <= 1'b0;
        end else begin
            s1_bin     <= bin_c;
            s1_bin_del <= bin_del_c;
            s1_valid   <= in_valid;
        end
    end

    // FSM: IDLE waits for the first sample (only loads prev_bin), PRIME
    // emits the first difference, RUN emits one per valid sample.
    state_t state_q;
    state_t state_d;
    logic   emit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s1_valid) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (s1_valid) begin
                    emit    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                emit = s1_valid;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fsm_state = state_q;

    // Stage 2 datapath
    logic [CNT_W-1:0]    prev_bin;
    logic [SUM_W-1:0]    acc;
    logic [CNT_BITS-1:0] cnt;

    logic [CNT_W-1:0] diff_c;
    logic [CNT_W-1:0] phase_c;
    logic [SUM_W-1:0] acc_next_c;
    logic             last_c;
    logic             over_c;
    logic             mis_c;

    // 6-bit subtraction wraps naturally, giving the modulo-64 increment.
    assign diff_c     = s1_bin - prev_bin;
    assign phase_c    = s1_bin - s1_bin_del;
    assign acc_next_c = acc + {{(SUM_W-CNT_W){1'b0}}, diff_c};
    assign last_c     = (cnt == LAST_CNT);
    assign over_c     = emit && (int'(diff_c) > MAX_STEP);
    // The delayed phase may lag by at most one count; anything else is a
    // sampling inconsistency. Reported for every valid sample, any state.
    assign mis_c      = s1_valid && (phase_c > 6'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_bin   <= '0;
            acc        <= '0;
            cnt        <= '0;
            diff_out   <= '0;
            diff_valid <= 1'b0;
            sum_out    <= '0;
            sum_valid  <= 1'b0;
            mis_flag   <= 1'b0;
        end else begin
            diff_valid <= emit;
            sum_valid  <= emit && last_c;
            mis_flag   <= mis_c;
            if (s1_valid) begin
                prev_bin <= s1_bin;
            end
            if (emit) begin
                diff_out <= diff_c;
                if (last_c) begin
                    sum_out <= acc_next_c;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= acc_next_c;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Sticky overrange: a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_flag <= 1'b0;
        end else if (over_c) begin
            ovr_flag <= 1'b1;
        end else if (clr_ovr) begin
            ovr_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cyborg65r2_coarse_decode.sv
// Bench for cyborg65r2_coarse_decode: a sequence-level model predicts every
// output each cycle, and directed scenarios pin the model with literal values.
module tb_cyborg65r2_coarse_decode;

    localparam int DECIM    = 8;
    localparam int MAX_STEP = 48;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [5:0]  grey_in;
    logic [5:0]  grey_del_in;
    logic        clr_ovr;
    logic [5:0]  diff_out;
    logic        diff_valid;
    logic [11:0] sum_out;
    logic        sum_valid;
    logic        ovr_flag;
    logic        mis_flag;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;

    cyborg65r2_coarse_decode #(.DECIM(DECIM), .MAX_STEP(MAX_STEP)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .grey_in     (grey_in),
        .grey_del_in (grey_del_in),
        .clr_ovr     (clr_ovr),
        .diff_out    (diff_out),
        .diff_valid  (diff_valid),
        .sum_out     (sum_out),
        .sum_valid   (sum_valid),
        .ovr_flag    (ovr_flag),
        .mis_flag    (mis_flag),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int g2b(input logic [5:0] g);
        logic [5:0] b;
        for (int i = 0; i < 6; i++) b[i] = ^(g >> i);
        return int'(b);
    endfunction

    function automatic logic [5:0] to_gray(input int v);
        logic [5:0] b;
        b = 6'(v % 64);
        return b ^ (b >> 1);
    endfunction

    // ---------------- model ----------------
    // Works on the sequence of valid samples: the k-th valid sample (k>=2)
    // yields a difference; every DECIM-th difference closes a sum.
    int m_nvalid, m_prev, m_ndiff, m_run;
    int p_dv, p_diff, p_sv, p_sum, p_mis;        // result of sample just taken
    int n_dv, n_sv, n_mis;                        // pulses visible this cycle
    int m_diff_out, m_sum_out, m_ovr;

    always @(posedge clk) begin
        if (reset) begin
            m_nvalid = 0; m_prev = 0; m_ndiff = 0; m_run = 0;
            p_dv = 0; p_diff = 0; p_sv = 0; p_sum = 0; p_mis = 0;
            n_dv = 0; n_sv = 0; n_mis = 0;
            m_diff_out = 0; m_sum_out = 0; m_ovr = 0;
        end else begin
            n_dv = p_dv; n_sv = p_sv; n_mis = p_mis;
            if (p_dv != 0) m_diff_out = p_diff;
            if (p_sv != 0) m_sum_out = p_sum;
            if (p_dv != 0 && p_diff > MAX_STEP) m_ovr = 1;
            else if (clr_ovr) m_ovr = 0;
            p_dv = 0; p_sv = 0; p_mis = 0;
            if (in_valid) begin
                int b, bd;
                b  = g2b(grey_in);
                bd = g2b(grey_del_in);
                p_mis = (((b - bd + 64) % 64) > 1) ? 1 : 0;
                m_nvalid++;
                if (m_nvalid > 1) begin
                    p_dv   = 1;
                    p_diff = (b - m_prev + 64) % 64;
                    m_ndiff++;
                    m_run += p_diff;
                    if (m_ndiff % DECIM == 0) begin
                        p_sv  = 1;
                        p_sum = m_run;
                        m_run = 0;
                    end
                end
                m_prev = b;
            end
        end
    end

    // ---------------- compare + pulse monitor ----------------
    int dv_cnt = 0, sv_cnt = 0, dv_at_sv = 0, sv_sum = 0;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_diff_out", int'(diff_out), 0);
            check("rst_diff_valid", int'(diff_valid), 0);
            check("rst_sum_out", int'(sum_out), 0);
            check("rst_sum_valid", int'(sum_valid), 0);
            check("rst_ovr", int'(ovr_flag), 0);
            check("rst_mis", int'(mis_flag), 0);
            check("rst_state", int'(fsm_state), 0);
        end else begin
            check("mdl_diff_valid", int'(diff_valid), n_dv);
            check("mdl_diff_out", int'(diff_out), m_diff_out);
            check("mdl_sum_valid", int'(sum_valid), n_sv);
            check("mdl_sum_out", int'(sum_out), m_sum_out);
            check("mdl_ovr", int'(ovr_flag), m_ovr);
            check("mdl_mis", int'(mis_flag), n_mis);
            if (diff_valid) dv_cnt++;
            if (sum_valid) begin
                sv_cnt++;
                dv_at_sv = dv_cnt;
                sv_sum   = int'(sum_out);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [5:0] g, input logic [5:0] gd,
                        input logic clr);
        in_valid    = v;
        grey_in     = g;
        grey_del_in = gd;
        clr_ovr     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 6'd0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        check("reset_state", int'(fsm_state), 0);
        check("reset_sum_out", int'(sum_out), 0);
        reset = 1'b0;
    endtask

    int dv0, sv0;

    initial begin
        reset = 1'b1; in_valid = 1'b0; grey_in = '0; grey_del_in = '0; clr_ovr = 1'b0;
        do_reset();

        // First difference: 0 then 5, result two cycles after the second sample
        step(1'b1, 6'b000000, 6'b000000, 1'b0);
        step(1'b1, 6'b000111, 6'b000111, 1'b0);
        check("first_no_pulse", int'(diff_valid), 0);
        check("prime_state", int'(fsm_state), 1);
        idle(1);
        check("first_dv", int'(diff_valid), 1);
        check("first_diff", int'(diff_out), 5);
        check("run_state", int'(fsm_state), 2);
        idle(1);
        check("first_dv_single", int'(diff_valid), 0);

        // Wrap 62 -> 3
        do_reset();
        step(1'b1, 6'b100001, 6'b100001, 1'b0);
        step(1'b1, 6'b000010, 6'b000010, 1'b0);
        idle(1);
        check("wrap_dv", int'(diff_valid), 1);
        check("wrap_diff", int'(diff_out), 5);
        check("wrap_ovr", int'(ovr_flag), 0);

        // Overrange 0 -> 50, clear, then set racing clear
        do_reset();
        step(1'b1, 6'b000000, 6'b000000, 1'b0);
        step(1'b1, 6'b101011, 6'b101011, 1'b0);
        idle(1);
        check("ovr_diff", int'(diff_out), 50);
        check("ovr_set", int'(ovr_flag), 1);
        idle(2);
        check("ovr_held", int'(ovr_flag), 1);
        step(1'b0, 6'd0, 6'd0, 1'b1);
        check("ovr_cleared", int'(ovr_flag), 0);
        step(1'b1, to_gray(36), to_gray(36), 1'b0);
        step(1'b0, 6'd0, 6'd0, 1'b1);
        check("ovr_race_dv", int'(diff_valid), 1);
        check("ovr_race_diff", int'(diff_out), 50);
        check("ovr_set_wins", int'(ovr_flag), 1);
        idle(1);
        check("ovr_sticky", int'(ovr_flag), 1);

        // Decimation: 9 samples stepping by 7 with gaps
        do_reset();
        dv0 = dv_cnt; sv0 = sv_cnt;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, to_gray(7 * i), to_gray(7 * i), 1'b0);
            if (i % 3 == 1) idle(1 + i % 2);
        end
        idle(3);
        check("dec_sv_count", sv_cnt - sv0, 1);
        check("dec_sum", sv_sum, 56);
        check("dec_sv_on_8th", dv_at_sv - dv0, 8);
        check("dec_dv_count", dv_cnt - dv0, 8);

        // Phase mismatch
        do_reset();
        step(1'b1, 6'b001111, 6'b000100, 1'b0);
        idle(1);
        check("mis_10_7", int'(mis_flag), 1);
        step(1'b1, 6'b001111, to_gray(9), 1'b0);
        idle(1);
        check("mis_10_9", int'(mis_flag), 0);
        step(1'b1, 6'b001111, 6'b001111, 1'b0);
        idle(1);
        check("mis_10_10", int'(mis_flag), 0);
        check("mis_diff_unaffected", int'(diff_out), 0);

        // Reset in the middle of a decimation frame
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, to_gray(3 * i), to_gray(3 * i), 1'b0);
        idle(1);
        check("mid_pre_diff", int'(diff_out), 3);
        reset = 1'b1;
        #1;
        check("mid_rst_diff", int'(diff_out), 0);
        check("mid_rst_dv", int'(diff_valid), 0);
        check("mid_rst_sum", int'(sum_out), 0);
        check("mid_rst_state", int'(fsm_state), 0);
        idle(1);
        reset = 1'b0;
        dv0 = dv_cnt; sv0 = sv_cnt;
        step(1'b1, to_gray(40), to_gray(40), 1'b0);
        idle(1);
        check("mid_reprime_no_dv", int'(diff_valid), 0);
        for (int i = 1; i <= 8; i++) step(1'b1, to_gray(40 + 2 * i), to_gray(40 + 2 * i), 1'b0);
        idle(3);
        check("mid_sv_count", sv_cnt - sv0, 1);
        check("mid_sum", sv_sum, 16);
        check("mid_sv_on_8th", dv_at_sv - dv0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
